// File: rtl/onchip_mem_bist_master.sv
// onchip_mem_bist_master: Avalon-MM BIST engine that fills or checks a word block against seed+i,
// or a Galois LFSR sequence when ONCHIP_BIST_LFSR_EN is defined.
module onchip_mem_bist_master #(
  parameter int ADDR_W = 15,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic              err_flag,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);
  localparam int NW = ADDR_W + 1;
  localparam logic [2:0] MAX_O = 3'(MAX_OUTSTANDING);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q;
  logic mode_q, rd_q, wr_q, busy_q, done_q, err_flag_q;
  logic [NW-1:0] num_q, i_q, j_q, i_d, j_d;
  logic [ADDR_W-1:0] a_q, aj_q, ferr_q;
  logic [31:0] pi_q, pj_q;
  logic [2:0] out_q, out_d;
  logic [15:0] err_cnt_q;
  logic acc, rsp, mis, last, rd_d, wr_d;
`ifdef ONCHIP_BIST_LFSR_EN
  localparam logic [31:0] TAPS = 32'h80200003;
  function automatic logic [31:0] nxt(input logic [31:0] p);
    return {1'b0, p[31:1]} ^ (p[0] ? TAPS : 32'h0);
  endfunction
  function automatic logic [31:0] ld(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction
`else
  function automatic logic [31:0] nxt(input logic [31:0] p);
    return p + 32'd1;
  endfunction
  function automatic logic [31:0] ld(input logic [31:0] s);
    return s;
  endfunction
`endif
  // Issue side (i, a, pi) and response side (j, aj, pj) advance independently.
  always_comb begin
    acc = (rd_q | wr_q) & ~avm_waitrequest;
    rsp = avm_readdatavalid & mode_q & ((state_q == ISSUE) | (state_q == DRAIN));
    i_d = i_q + NW'(acc);
    j_d = j_q + NW'(rsp);
    out_d = out_q + 3'(acc & rd_q) - 3'(rsp);
    mis = rsp & (avm_readdata != pj_q);
    last = acc & (i_d == num_q);
    rd_d = (i_d < num_q) & (out_d < MAX_O);
    wr_d = i_d < num_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q <= '0;
      ferr_q <= '0;
      num_q <= '0;
      i_q <= '0;
      j_q <= '0;
      out_q <= '0;
      a_q <= '0;
      aj_q <= '0;
      pi_q <= '0;
      pj_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      out_q <= out_d;
      if (acc) begin
        a_q <= a_q + ADDR_W'(1);
        pi_q <= nxt(pi_q);
      end
      if (rsp) begin
        aj_q <= aj_q + ADDR_W'(1);
        pj_q <= nxt(pj_q);
      end
      if (mis) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        if (!err_flag_q) begin
          err_flag_q <= 1'b1;
          ferr_q <= aj_q;
        end
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && num_words != '0) begin
            state_q <= ISSUE;
            busy_q <= 1'b1;
            mode_q <= mode;
            num_q <= num_words;
            rd_q <= mode;
            wr_q <= ~mode;
            a_q <= base_addr;
            aj_q <= base_addr;
            pi_q <= ld(seed);
            pj_q <= ld(seed);
            i_q <= '0;
            j_q <= '0;
            out_q <= '0;
            err_cnt_q <= '0;
            err_flag_q <= 1'b0;
            ferr_q <= '0;
          end else if (start) begin
            state_q <= DONE;
            done_q <= 1'b1;
          end
        end
        ISSUE: begin
          rd_q <= mode_q & rd_d;
          wr_q <= ~mode_q & wr_d;
          if (last) begin
            state_q <= mode_q ? DRAIN : DONE;
            done_q <= ~mode_q;
            busy_q <= mode_q;
          end
        end
        DRAIN: begin
          if (out_d == '0 && j_d == num_q) begin
            state_q <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: begin
          done_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err_count = err_cnt_q;
  assign err_flag = err_flag_q;
  assign first_err_addr = ferr_q;
  assign avm_address = {a_q, 2'b00};
  assign avm_read = rd_q;
  assign avm_write = wr_q;
  assign avm_writedata = pi_q;
  assign avm_byteenable = 4'hF;
endmodule

// File: tb/tb_onchip_mem_bist_master.sv
// tb_onchip_mem_bist_master: directed FILL/CHECK runs against a behavioural memory and pattern model.
module tb_onchip_mem_bist_master;
  localparam int AW = 15;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] num_words = '0;
  logic [31:0] seed = '0;
  logic busy, done, err_flag;
  logic [15:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic [AW+1:0] avm_address;
  logic avm_read, avm_write, avm_readdatavalid, avm_waitrequest;
  logic [31:0] avm_writedata, avm_readdata;
  logic [3:0] avm_byteenable;
  bit [31:0] mem [0:32767];
  logic stall_en = 1'b0, wt_q = 1'b0, rdv_q = 1'b0, pk_en = 1'b0;
  logic [31:0] rdd_q = '0, pk_v = '0;
  logic [AW-1:0] pk_a = '0;
  int checks = 0, errors = 0;
  logic active = 1'b0;
  int wk = 0, rk = 0;
  logic [AW-1:0] m_base = '0;
  logic [31:0] m_seed = '0;
  logic prev_stall = 1'b0;
  logic [50:0] prev_req = '0;
  int d;

  onchip_mem_bist_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy), .done(done), .err_count(err_count),
    .err_flag(err_flag), .first_err_addr(first_err_addr), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;
  assign avm_waitrequest = wt_q;
  assign avm_readdatavalid = rdv_q;
  assign avm_readdata = rdd_q;

  // One-cycle-latency on-chip memory slave with optional alternating stall.
  always @(posedge clk) begin
    wt_q <= stall_en ? ~wt_q : 1'b0;
    rdv_q <= avm_read && !avm_waitrequest;
    if (avm_read && !avm_waitrequest) rdd_q <= mem[avm_address[AW+1:2]];
    if (avm_write && !avm_waitrequest) mem[avm_address[AW+1:2]] <= avm_writedata;
    if (pk_en) mem[pk_a] <= pk_v;
  end

  function automatic logic [31:0] pat(input logic [31:0] s, input int k);
    logic [31:0] p;
`ifdef ONCHIP_BIST_LFSR_EN
    p = (s == 32'h0) ? 32'h1 : s;
    for (int x = 0; x < k; x++) p = p[0] ? ((p >> 1) ^ 32'h80200003) : (p >> 1);
`else
    p = s + 32'(k);
`endif
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("byteenable", 64'(avm_byteenable), 64'h F);
    if (reset_n) begin
      if (prev_stall)
        chk("stall_hold", 64'({avm_address, avm_read, avm_write, avm_writedata}), 64'(prev_req));
      if (!active) chk("idle_bus", 64'({avm_read, avm_write}), 64'd0);
      chk("busy", 64'(busy), 64'(active && !done));
      if (avm_write && !avm_waitrequest) begin
        chk("wr_addr", 64'(avm_address), 64'({m_base + AW'(wk), 2'b00}));
        chk("wr_data", 64'(avm_writedata), 64'(pat(m_seed, wk)));
        wk++;
      end
      if (avm_read && !avm_waitrequest) begin
        chk("rd_addr", 64'(avm_address), 64'({m_base + AW'(rk), 2'b00}));
        rk++;
      end
    end
    prev_stall = (avm_read || avm_write) && avm_waitrequest;
    prev_req = {avm_address, avm_read, avm_write, avm_writedata};
  end

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] v);
    pk_a = a;
    pk_v = v;
    pk_en = 1'b1;
    @(posedge clk);
    #1 pk_en = 1'b0;
  endtask

  task automatic run(input logic m, input logic [AW-1:0] b, input logic [AW:0] n,
                     input logic [31:0] s, output int dcyc);
    int ecnt;
    logic [AW-1:0] efirst;
    ecnt = 0;
    efirst = '0;
    for (int k = 0; k < int'(n); k++)
      if (mem[b + AW'(k)] != pat(s, k)) begin
        if (ecnt == 0) efirst = b + AW'(k);
        ecnt++;
      end
    m_base = b;
    m_seed = s;
    wk = 0;
    rk = 0;
    mode = m;
    base_addr = b;
    num_words = n;
    seed = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    active = (n != 0);
    dcyc = -1;
    for (int t = 1; t <= 4000 && dcyc < 0; t++) begin
      @(negedge clk);
      #1;
      if (done) dcyc = t;
    end
    chk("done_seen", 64'(dcyc >= 0), 64'd1);
    active = 1'b0;
    if (m) begin
      chk("reads", 64'(rk), 64'(n));
      chk("no_writes", 64'(wk), 64'd0);
    end else begin
      chk("writes", 64'(wk), 64'(n));
      chk("no_reads", 64'(rk), 64'd0);
    end
    if (n != 0) begin
      chk("err_count", 64'(err_count), m ? 64'(ecnt) : 64'd0);
      chk("err_flag", 64'(err_flag), 64'(m && ecnt != 0));
      if (m && ecnt != 0) chk("first_err", 64'(first_err_addr), 64'(efirst));
    end
    @(posedge clk);
    #1 chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_read", 64'(avm_read), 64'd0);
    chk("rst_write", 64'(avm_write), 64'd0);
    chk("rst_addr", 64'(avm_address), 64'd0);
    chk("rst_wdata", 64'(avm_writedata), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    chk("rst_errflag", 64'(err_flag), 64'd0);
    chk("rst_firsterr", 64'(first_err_addr), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run(1'b0, 15'h0010, 16'd4, 32'hA5A50000, d);
    chk("fill_done_cycle", 64'(d), 64'd5);
`ifndef ONCHIP_BIST_LFSR_EN
    chk("mem_0x10", 64'(mem[16]), 64'hA5A50000);
    chk("mem_0x11", 64'(mem[17]), 64'hA5A50001);
    chk("mem_0x12", 64'(mem[18]), 64'hA5A50002);
    chk("mem_0x13", 64'(mem[19]), 64'hA5A50003);
`endif
    run(1'b1, 15'h0010, 16'd4, 32'hA5A50000, d);
    chk("check_done_cycle", 64'(d), 64'd6);
    chk("check_clean", 64'(err_count), 64'd0);
    stall_en = 1'b1;
    run(1'b0, 15'h0020, 16'd7, 32'h12345678, d);
    run(1'b1, 15'h0020, 16'd7, 32'h12345678, d);
    chk("stall_check_clean", 64'({err_flag, err_count}), 64'd0);
    poke(15'h0022, 32'h0);
    poke(15'h0024, 32'h1);
    run(1'b1, 15'h0020, 16'd7, 32'h12345678, d);
    chk("two_err_count", 64'(err_count), 64'd2);
    chk("two_err_first", 64'(first_err_addr), 64'h22);
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    poke(15'h0012, 32'hDEADBEEF);
    run(1'b1, 15'h0010, 16'd4, 32'hA5A50000, d);
    chk("corrupt_done_cycle", 64'(d), 64'd6);
    chk("corrupt_count", 64'(err_count), 64'd1);
    chk("corrupt_first", 64'(first_err_addr), 64'h12);
    chk("corrupt_flag", 64'(err_flag), 64'd1);
    run(1'b0, 15'h7FFE, 16'd4, 32'h11110000, d);
`ifndef ONCHIP_BIST_LFSR_EN
    chk("wrap_7ffe", 64'(mem[15'h7FFE]), 64'h11110000);
    chk("wrap_7fff", 64'(mem[15'h7FFF]), 64'h11110001);
    chk("wrap_0000", 64'(mem[0]), 64'h11110002);
    chk("wrap_0001", 64'(mem[1]), 64'h11110003);
`endif
    run(1'b1, 15'h7FFE, 16'd4, 32'h11110000, d);
    chk("wrap_check_clean", 64'(err_count), 64'd0);
    run(1'b0, 15'h0300, 16'd0, 32'h5, d);
    chk("zero_done_cycle", 64'(d), 64'd1);
`ifdef ONCHIP_BIST_LFSR_EN
    run(1'b0, 15'h0400, 16'd8, 32'h0, d);
    chk("lfsr_first_word", 64'(mem[15'h0400]), 64'h1);
    run(1'b1, 15'h0400, 16'd8, 32'h0, d);
    chk("lfsr_check_clean", 64'(err_count), 64'd0);
`endif
    m_base = 15'h0200;
    m_seed = 32'h7;
    wk = 0;
    rk = 0;
    mode = 1'b0;
    base_addr = 15'h0200;
    num_words = 16'd100;
    seed = 32'h7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    active = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 active = 1'b0;
    chk("midrst_write", 64'(avm_write), 64'd0);
    chk("midrst_read", 64'(avm_read), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run(1'b0, 15'h0500, 16'd2, 32'hCAFE0000, d);
    chk("post_rst_fill", 64'(d), 64'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
